// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: opcode constants,
// iteration count and the sequencer state encoding.
package mult_hilo_unit_pkg;

    localparam logic [3:0] OP_MULT    = 4'b0110;
    localparam int         MULT_ITERS = 32;
    localparam logic [5:0] LAST_ITER  = 6'(MULT_ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// Iterative shift-add datapath: unsigned 32x32 magnitude product built
// one multiplier bit per clock into a 64-bit accumulator.
module mult_shift_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic [63:0] product,
    output logic [5:0]  count
);

    logic [31:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [63:0] product_reg;
    logic [5:0]  count_reg;
    logic [63:0] addend;

    assign addend = {32'd0, mcand_reg} << count_reg[4:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            product_reg <= '0;
            count_reg   <= '0;
        end else if (load) begin
            mcand_reg   <= mcand;
            mplier_reg  <= mplier;
            product_reg <= '0;
            count_reg   <= '0;
        end else if (step) begin
            if (mplier_reg[count_reg[4:0]])
                product_reg <= product_reg + addend;
            count_reg <= count_reg + 6'd1;
        end
    end

    assign product = product_reg;
    assign count   = count_reg;

endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle signed multiplier owning the architectural HI/LO registers,
// with a pipeline stall request while a mult is in flight.
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  op_EX,
    input  logic        enhilo_EX,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_rd,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_EX,
    output logic        done
);

    mult_state_e state_reg, state_next;
    logic [31:0] hi_reg, lo_reg;
    logic        done_reg;
    logic        sign_reg;
    logic        start, load, step;
    logic [31:0] rs_mag, rt_mag;
    logic [63:0] product;
    logic [5:0]  count;

    assign start  = enhilo_EX && (op_EX == OP_MULT);
    // Two's-complement magnitude; 0x80000000 maps to itself, which is exact unsigned.
    assign rs_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign rt_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;

    mult_shift_add u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .mcand   (rs_mag),
        .mplier  (rt_mag),
        .product (product),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST_ITER)
                    state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // HI/LO only change on direct writes in IDLE or on the FIN edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
            sign_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sign_reg <= rs_val[31] ^ rt_val[31];
                    end else begin
                        if (hi_we) hi_reg <= rs_val;
                        if (lo_we) lo_reg <= rs_val;
                    end
                end
                FIN: begin
                    {hi_reg, lo_reg} <= sign_reg ? -product : product;
                    done_reg         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign stall_EX = busy && (start || hilo_rd || hi_we || lo_we);
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Scoreboard bench for mult_hilo_unit: randomized mults checked against a
// signed 64-bit arithmetic reference, plus reset/abort and HI/LO write cases.
module tb_mult_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  op_EX = 4'd0;
    logic        enhilo_EX = 1'b0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        hilo_rd = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall_EX, done;

    localparam logic [3:0] MULT_OPC = 4'b0110;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    mult_hilo_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_EX     (op_EX),
        .enhilo_EX (enhilo_EX),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .hilo_rd   (hilo_rd),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_EX  (stall_EX),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding mult.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_exp = exp_q.pop_front();
                check("mult_result", {hi, lo}, mon_exp);
                $display("mult done: hi=%h lo=%h expected=%h", hi, lo, mon_exp);
            end
        end
    end

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input bit lo_with_start, input bit mthi_in_run,
                           input logic [31:0] mthi_val, input bit rand_rd);
        logic [31:0] hi0, lo0;
        logic [63:0] expv;
        int  cnt;
        bit  changed, stall_ok, start_now, exp_stall;
        hi0  = hi;
        lo0  = lo;
        expv = ref_mult(a, b);
        op_EX = MULT_OPC; enhilo_EX = 1'b1; rs_val = a; rt_val = b; lo_we = lo_with_start;
        exp_q.push_back(expv);
        #1;
        check("stall_idle_start", 64'(stall_EX), 64'd0);
        @(posedge clk); #1;
        lo_we = 1'b0;
        if (mthi_in_run) begin
            enhilo_EX = 1'b0; hi_we = 1'b1; rs_val = mthi_val;
        end else begin
            // Upstream may keep a new mult presented; it must not be relatched.
            enhilo_EX = 1'($urandom_range(0, 1)); rs_val = $urandom; rt_val = $urandom;
        end
        cnt = 0; changed = 0; stall_ok = 1;
        while (busy && cnt < 100) begin
            cnt++;
            if (hi !== hi0 || lo !== lo0) changed = 1;
            if (rand_rd) hilo_rd = 1'($urandom_range(0, 1));
            #1;
            start_now = enhilo_EX && (op_EX == MULT_OPC);
            exp_stall = start_now || hilo_rd || hi_we || lo_we;
            if (stall_EX !== exp_stall) stall_ok = 0;
            @(posedge clk); #1;
        end
        check("busy_cycles", 64'(cnt), 64'd33);
        check("hilo_held_during_run", 64'(changed), 64'd0);
        check("stall_while_busy", 64'(stall_ok), 64'd1);
        check("stall_idle_after", 64'(stall_EX), 64'd0);
        enhilo_EX = 1'b0; hilo_rd = 1'b0;
        if (mthi_in_run) begin
            @(posedge clk); #1;
            hi_we = 1'b0;
            check("mthi_applied_idle", 64'(hi), 64'(mthi_val));
            check("lo_after_mthi", 64'(lo), 64'(expv[31:0]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        int wd;
        // Reset with a direct write presented: must be ignored.
        hi_we = 1'b1; rs_val = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        hi_we = 1'b0; rst_n = 1'b1;
        hilo_rd = 1'b1; #1;
        check("stall_after_reset", 64'(stall_EX), 64'd0);
        hilo_rd = 1'b0;
        @(posedge clk); #1;

        do_mult(32'd7, 32'd6, 0, 0, 32'd0, 0);
        check("mult_7x6", {32'd0, lo}, 64'h2A);
        do_mult(32'hFFFF_FFFF, 32'd5, 0, 0, 32'd0, 0);
        check("mult_m1x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
        do_mult(32'h8000_0000, 32'h8000_0000, 0, 0, 32'd0, 0);
        check("mult_min_sq", {hi, lo}, 64'h4000_0000_0000_0000);
        do_mult(32'hFFFF_FFF9, 32'd3, 1, 0, 32'd0, 1);
        do_mult(32'h0001_0001, 32'h8000_0000, 0, 1, 32'hCAFE_F00D, 1);

        for (int i = 0; i < 25; i++) begin
            a = pick_operand();
            b = pick_operand();
            do_mult(a, b, 1'($urandom_range(0, 1)), 0, 32'd0, 1);
        end

        // Abort a mult mid-RUN after presetting HI.
        hi_we = 1'b1; rs_val = 32'h0000_1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_preset", 64'(hi), 64'h1234);
        op_EX = MULT_OPC; enhilo_EX = 1'b1; rs_val = $urandom; rt_val = $urandom;
        @(posedge clk); #1;
        enhilo_EX = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("busy_before_abort", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        hilo_rd = 1'b1; #1;
        check("abort_stall", 64'(stall_EX), 64'd0);
        hilo_rd = 1'b0;
        wd = 0;
        while (wd < 40) begin
            @(posedge clk);
            wd++;
        end
        #1;
        check("abort_no_late_write", {hi, lo}, 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
